// File: rtl/id_hazard_ctrl.sv
// Decode-stage interlock: a pending-write scoreboard stalls RAW/WAW hazards and a counter
// sequences flush bubbles after a taken jump. Define WB_BYPASS_EN to let a same-cycle
// writeback resolve a hazard; the register bank must then forward the write data.
module id_hazard_ctrl #(
    parameter int unsigned NREG      = 8,
    parameter int unsigned REG_W     = 3,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic             id_src1_use,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src2_use,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_wr,
    input  logic             id_jump,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_dst,
    output logic             issue,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic [NREG-1:0]  busy_mask,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_wb
);

    typedef enum logic [1:0] {
        StRun,
        StStall,
        StFlush
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [NREG-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             err_q, err_d;

    logic [NREG-1:0]  wb_mask;
    logic [NREG-1:0]  set_mask;
    logic [NREG-1:0]  hz_pend;
    logic             hz;

    assign wb_mask = wb_valid ? (NREG'(1) << wb_dst) : '0;

`ifdef WB_BYPASS_EN
    assign hz_pend = pend_q & ~wb_mask;
`else
    assign hz_pend = pend_q;
`endif

    assign hz = (id_src1_use & hz_pend[id_src1]) |
                (id_src2_use & hz_pend[id_src2]) |
                (id_wr & hz_pend[id_dst]);

    // RUN and STALL decode identically; STALL only records that the held instruction waits.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        issue   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StRun, StStall: begin
                    if (!id_valid) begin
                        state_d = StRun;
                    end else if (hz) begin
                        stall   = 1'b1;
                        state_d = StStall;
                    end else begin
                        issue = 1'b1;
                        if (id_jump) begin
                            state_d = StFlush;
                            fcnt_d  = 3'(FLUSH_CYC);
                        end else begin
                            state_d = StRun;
                        end
                    end
                end
                StFlush: begin
                    flush = 1'b1;
                    if (fcnt_q <= 3'd1) begin
                        state_d = StRun;
                        fcnt_d  = 3'd0;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = StRun;
                    fcnt_d  = 3'd0;
                end
            endcase
        end
    end

    assign bubble = stall | flush;

    // A new outstanding write to the register being written back stays pending.
    always_comb begin
        set_mask    = (issue & id_wr) ? (NREG'(1) << id_dst) : '0;
        pend_d      = (pend_q & ~wb_mask) | set_mask;
        err_d       = err_q | (wb_valid & ~pend_q[wb_dst]);
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            fcnt_q      <= 3'd0;
            pend_q      <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign busy_mask = pend_q;
    assign stall_cnt = stall_cnt_q;
    assign err_wb    = err_q;

    stall_flush_excl: assert property (@(posedge clk) disable iff (rst) !(stall && flush));

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: a behavioural model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_id_hazard_ctrl;

    localparam int NREG      = 8;
    localparam int REG_W     = 3;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic             id_src1_use;
    logic [REG_W-1:0] id_src2;
    logic             id_src2_use;
    logic [REG_W-1:0] id_dst;
    logic             id_wr;
    logic             id_jump;
    logic             wb_valid;
    logic [REG_W-1:0] wb_dst;
    logic             issue;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic [NREG-1:0]  busy_mask;
    logic [CNT_W-1:0] stall_cnt;
    logic             err_wb;

    id_hazard_ctrl #(
        .NREG      (NREG),
        .REG_W     (REG_W),
        .FLUSH_CYC (FLUSH_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src1     (id_src1),
        .id_src1_use (id_src1_use),
        .id_src2     (id_src2),
        .id_src2_use (id_src2_use),
        .id_dst      (id_dst),
        .id_wr       (id_wr),
        .id_jump     (id_jump),
        .wb_valid    (wb_valid),
        .wb_dst      (wb_dst),
        .issue       (issue),
        .stall       (stall),
        .bubble      (bubble),
        .flush       (flush),
        .busy_mask   (busy_mask),
        .stall_cnt   (stall_cnt),
        .err_wb      (err_wb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             issue;
        logic             stall;
        logic             bubble;
        logic             flush;
        logic [NREG-1:0]  busy;
        logic [CNT_W-1:0] cnt;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Model state: set of registers with outstanding writes, flush cycles left, counters.
    bit   m_pend[NREG];
    int   m_flush_left;
    int   m_cnt;
    bit   m_err;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("issue", int'(issue), int'(mon_e.issue));
            chk("stall", int'(stall), int'(mon_e.stall));
            chk("bubble", int'(bubble), int'(mon_e.bubble));
            chk("flush", int'(flush), int'(mon_e.flush));
            chk("busy_mask", int'(busy_mask), int'(mon_e.busy));
            chk("stall_cnt", int'(stall_cnt), int'(mon_e.cnt));
            chk("err_wb", int'(err_wb), int'(mon_e.err));
        end
    end

    task automatic drive(input bit r, input bit v, input int s1, input bit s1u,
                         input int s2, input bit s2u, input int d, input bit w,
                         input bit j, input bit wv, input int wd);
        exp_t e;
        bit   eff[NREG];
        bit   hz;
        @(posedge clk);
        #1;
        cyc++;
        rst         = r;
        id_valid    = v;
        id_src1     = REG_W'(s1);
        id_src1_use = s1u;
        id_src2     = REG_W'(s2);
        id_src2_use = s2u;
        id_dst      = REG_W'(d);
        id_wr       = w;
        id_jump     = j;
        wb_valid    = wv;
        wb_dst      = REG_W'(wd);

        e = '0;
        for (int i = 0; i < NREG; i++) begin
            e.busy[i] = m_pend[i];
        end
        e.cnt = CNT_W'(m_cnt);
        e.err = m_err;

        eff = m_pend;
`ifdef WB_BYPASS_EN
        if (wv) eff[wd] = 1'b0;
`endif
        hz = (s1u && eff[s1]) || (s2u && eff[s2]) || (w && eff[d]);

        if (!r) begin
            if (m_flush_left > 0) begin
                e.flush  = 1'b1;
                e.bubble = 1'b1;
            end else if (v) begin
                e.stall  = hz;
                e.bubble = hz;
                e.issue  = !hz;
            end
        end
        exp_q.push_back(e);

        if (r) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_flush_left = 0;
            m_cnt        = 0;
            m_err        = 1'b0;
        end else begin
            if (wv) begin
                if (!m_pend[wd]) m_err = 1'b1;
                m_pend[wd] = 1'b0;
            end
            if (e.issue && w) m_pend[d] = 1'b1;
            if (e.stall && m_cnt < CNT_MAX) m_cnt++;
            if (m_flush_left > 0) m_flush_left--;
            else if (e.issue && j) m_flush_left = FLUSH_CYC;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cycle();
        int wd;
        int pick;
        wd = int'($urandom_range(NREG - 1));
        // Prefer writing back a register that really is pending.
        if ($urandom_range(4) != 0) begin
            pick = int'($urandom_range(NREG - 1));
            for (int k = 0; k < NREG; k++) begin
                if (m_pend[(pick + k) % NREG]) begin
                    wd = (pick + k) % NREG;
                    break;
                end
            end
        end
        drive($urandom_range(63) == 0, $urandom_range(3) != 0,
              int'($urandom_range(NREG - 1)), $urandom_range(1) == 1,
              int'($urandom_range(NREG - 1)), $urandom_range(2) == 0,
              int'($urandom_range(NREG - 1)), $urandom_range(1) == 1,
              $urandom_range(7) == 0, $urandom_range(2) == 0, wd);
    endtask

    initial begin
        rst = 1'b1; id_valid = 0; id_src1 = 0; id_src1_use = 0; id_src2 = 0;
        id_src2_use = 0; id_dst = 0; id_wr = 0; id_jump = 0; wb_valid = 0; wb_dst = 0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_flush_left = 0;
        m_cnt        = 0;
        m_err        = 1'b0;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 2, 1, 3, 1, 1, 1, 4);

        // Write to r3, then retire it.
        drive(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        idle(1);

        // RAW on r3: stall until writeback.
        drive(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 3, 1, 0, 0, 1, 0, 0, 1, 3);
        drive(0, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0);
        idle(1);

        // Jump: flush bubbles with id_valid ignored, then issue resumes.
        drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);

        // r5 pending, new write to r5 in the same cycle as its writeback.
        drive(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 5);
        drive(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        idle(2);

        // Writeback to non-pending r6 sets sticky error.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        idle(2);

        // Fill every register, stall long enough to saturate, then reset mid-stall.
        for (int r = 0; r < NREG; r++) drive(0, 1, 0, 0, 0, 0, r, 1, 0, 0, 0);
        for (int k = 0; k < CNT_MAX + 4; k++) drive(0, 1, 0, 1, 7, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 7, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 7, 1, 0, 0, 0, 0, 0);
        idle(1);

        for (int k = 0; k < 600; k++) rand_cycle();
        idle(2);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Scoreboard-based interlock controller for the decode stage. Sits beside the ID stage, which contains the instruction decoder, control unit and register bank.
- Tracks register-bank destinations with an outstanding writeback. Stalls decode on RAW/WAW hazards against those registers.
- Sequences pipeline flush bubbles after a taken jump.
- Drives stall/bubble/flush to the fetch/decode pipeline registers and reports stall statistics.

Parameters:
- NREG, 8, number of architectural registers in the register bank.
- REG_W, 3, register index width (log2 NREG).
- FLUSH_CYC, 2, bubble cycles inserted after a jump issues (1..7).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  decoded instruction present in ID this cycle
- id_src1  in  REG_W  first source register index
- id_src1_use  in  1  instruction reads id_src1
- id_src2  in  REG_W  second source register index
- id_src2_use  in  1  instruction reads id_src2
- id_dst  in  REG_W  destination register index
- id_wr  in  1  instruction writes id_dst (control-unit writeback enable)
- id_jump  in  1  instruction is a jump (control-unit jump enable)
- wb_valid  in  1  register bank written this cycle
- wb_dst  in  REG_W  register written by writeback
- issue  out  1  instruction in ID advances to EXE this cycle
- stall  out  1  hold PC and IF/ID register
- bubble  out  1  load NOP into ID/EXE register
- flush  out  1  squash IF/ID contents
- busy_mask  out  NREG  pending-write bitmap, bit i = register i pending
- stall_cnt  out  CNT_W  saturating count of stall cycles
- err_wb  out  1  sticky: wb_valid seen for a non-pending register

Behaviour:
- Reset (sync, rst=1 at posedge clk):
  - pending=0, state=RUN, flush counter=0, stall_cnt=0, err_wb=0.
  - Combinational outputs are 0 while rst=1.
  - Reset mid-stall or mid-flush drops all outstanding state; there is no drain.
- Hazard (combinational, from registered pending after optional bypass):
  - hz = (src1_use & pend[src1]) | (src2_use & pend[src2]) | (id_wr & pend[dst]).
- States:
  - RUN: id_valid & ~hz → issue=1.
    - If id_jump, next state FLUSH with counter=FLUSH_CYC.
    - id_valid & hz → stall=1, bubble=1, next state STALL.
  - STALL: stall=bubble=1 while hz. When hz clears, issue=1 that same cycle, then next state RUN, or FLUSH if id_jump.
  - FLUSH: flush=1, bubble=1, issue=0, stall=0. id_valid is ignored (squashed). Counter decrements each cycle; when it reaches 1, next state RUN.
- Issue latency: 0 cycles from the hazard clearing to issue. The pending bit is set at the posedge following issue.
- Scoreboard update each posedge:
  - issue & id_wr sets pend[id_dst].
  - wb_valid clears pend[wb_dst].
  - Set and clear of the same index in the same cycle: set wins, since the new write is outstanding.
  - wb_valid to a register with pend=0: no state change, err_wb←1 (sticky until rst).
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.
- Outputs: busy_mask=pending (registered); issue/stall/bubble/flush are combinational from state plus inputs.
- stall and flush are never asserted together. bubble=stall|flush.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - The hazard check uses pend & ~(wb_valid ? onehot(wb_dst) : 0).
  - A writeback in the same cycle resolves the hazard, and the consumer issues that cycle. The register bank must forward write data within that cycle.
- Undefined:
  - The hazard uses registered pend only.
  - The consumer issues one cycle after the writeback cycle.

Test Plan:
- Reset, then id_valid with id_wr=1, dst=3, no sources → issue=1 at cycle 0; busy_mask=8'h08 at cycle 1. Then wb_valid, wb_dst=3 → busy_mask=0 the next cycle.
- r3 pending; id_src1=3 with src1_use=1 held valid → stall=bubble=1 and stall_cnt counting. wb_dst=3 at cycle 4 → issue at cycle 5 without WB_BYPASS_EN, or cycle 4 with it.
- Jump issues with FLUSH_CYC=2 → flush=bubble=1 for exactly 2 cycles; id_valid ignored during flush; issue resumes cycle 3.
- Same cycle: issue writes dst=5 and wb_dst=5 (r5 previously pending) → busy_mask bit5 remains 1.
- wb_valid, wb_dst=6 with r6 not pending → err_wb=1 and stays 1 until rst; busy_mask unchanged.
- rst asserted in STALL with busy_mask=8'hFF → next cycle busy_mask=0, stall=0, stall_cnt=0, state RUN.
